// File: rtl/ft64v8d_insn_align_if.sv
// Fetch/decode handshake bundle for the FT64v8d instruction aligner.
// The aligner takes the slave view; the fetch and decode side takes the master view.
interface ft64v8d_insn_align_if #(parameter int AMSB = 31);
    logic            flush_i;
    logic [AMSB:0]   flush_pc_i;
    logic            fetch_valid_i;
    logic [63:0]     fetch_data_i;
    logic            fetch_ready_o;
    logic            insn_valid_o;
    logic [55:0]     insn_o;
    logic [2:0]      insn_len_o;
    logic [AMSB:0]   insn_pc_o;
    logic            insn_ready_i;

    modport master (
        output flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, insn_ready_i,
        input  fetch_ready_o, insn_valid_o, insn_o, insn_len_o, insn_pc_o
    );
    modport slave (
        input  flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, insn_ready_i,
        output fetch_ready_o, insn_valid_o, insn_o, insn_len_o, insn_pc_o
    );
endinterface

// File: rtl/ft64v8d_insn_align.sv
// FT64v8d byte-stream aligner: 16-byte queue feeding one variable-length insn per cycle.
// Optional FT64_PREFIX_FUSE_EN fuses a size-prefix head byte with the following insn.
package ft64v8d_insn_pkg;
    localparam logic [7:0] I_NOP   = 8'hEA;
    localparam logic [7:0] I_MOV   = 8'h01;
    localparam logic [7:0] I_ADD   = 8'h02;
    localparam logic [7:0] I_ADD14 = 8'h04;
    localparam logic [7:0] I_ADD30 = 8'h05;
    localparam logic [7:0] I_ADD22 = 8'h06;
    localparam logic [7:0] I_BYTE  = 8'h40;
    localparam logic [7:0] I_UBYTE = 8'h41;
    localparam logic [7:0] I_HALF  = 8'h42;
    localparam logic [7:0] I_UHALF = 8'h43;
    localparam logic [7:0] I_WORD  = 8'h44;
    localparam logic [7:0] I_UWORD = 8'h45;
endpackage

module ft64v8d_insn_len (
    input  logic [7:0] op_i,
    output logic [2:0] len_o
);
    import ft64v8d_insn_pkg::*;

    always_comb begin
        len_o = 3'd1;
        case (op_i)
            I_MOV:   len_o = 3'd2;
            I_ADD:   len_o = 3'd3;
            I_ADD14: len_o = 3'd4;
            I_ADD22: len_o = 3'd5;
            I_ADD30: len_o = 3'd6;
            I_NOP, I_BYTE, I_UBYTE, I_HALF, I_UHALF, I_WORD, I_UWORD: len_o = 3'd1;
            default: len_o = 3'd1;
        endcase
    end
endmodule

module ft64v8d_insn_align #(
    parameter int AMSB = 31
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    ft64v8d_insn_align_if.slave    bus
);
    localparam int AW = AMSB + 1;

    logic [15:0][7:0] q_q, q_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [AMSB:0]    pc_q, pc_d;
    logic [2:0]       skip_q, skip_d;

    logic [2:0]       len0, len;
    logic             fetch_ready, insn_valid, deq, acc;
    logic [2:0]       deq_len;
    logic [4:0]       cnt_s;
    logic [3:0]       nb;
    logic [7:0][7:0]  wb;
    logic [6:0][7:0]  insn;

    ft64v8d_insn_len u_len0 (.op_i(q_q[0]), .len_o(len0));

`ifdef FT64_PREFIX_FUSE_EN
    logic [2:0] len1;
    logic       pfx0;
    ft64v8d_insn_len u_len1 (.op_i(q_q[1]), .len_o(len1));
    // A prefix at q[1] decodes to 1, so a double prefix fuses to length 2 only.
    assign pfx0 = q_q[0] inside {ft64v8d_insn_pkg::I_BYTE, ft64v8d_insn_pkg::I_UBYTE,
                                 ft64v8d_insn_pkg::I_HALF, ft64v8d_insn_pkg::I_UHALF,
                                 ft64v8d_insn_pkg::I_WORD, ft64v8d_insn_pkg::I_UWORD};
    assign len  = pfx0 ? len1 + 3'd1 : len0;
`else
    assign len  = len0;
`endif

    always_comb begin
        fetch_ready = (cnt_q <= 5'd8) & ~bus.flush_i;
        insn_valid  = ({2'b00, len} <= cnt_q) & ~bus.flush_i;
        deq         = insn_valid & bus.insn_ready_i;
        acc         = bus.fetch_valid_i & fetch_ready;
        deq_len     = deq ? len : 3'd0;
        cnt_s       = cnt_q - {2'b00, deq_len};
        nb          = 4'd8 - {1'b0, skip_q};
        // Bytes below the skip offset belong to addresses before the redirect target.
        wb          = bus.fetch_data_i >> {skip_q, 3'b000};

        q_d = '0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) + {2'b00, deq_len} < 5'd16)
                q_d[i] = q_q[4'(i) + {1'b0, deq_len}];
            if (acc && (5'(i) >= cnt_s) && (5'(i) - cnt_s < {1'b0, nb}))
                q_d[i] = wb[3'(5'(i) - cnt_s)];
        end

        cnt_d  = cnt_s + (acc ? {1'b0, nb} : 5'd0);
        pc_d   = pc_q + AW'(deq_len);
        skip_d = acc ? 3'd0 : skip_q;

        if (bus.flush_i) begin
            q_d    = q_q;
            cnt_d  = 5'd0;
            pc_d   = bus.flush_pc_i;
            skip_d = bus.flush_pc_i[2:0];
        end

        insn = '0;
        for (int b = 0; b < 7; b++)
            if (insn_valid && (3'(b) < len))
                insn[b] = q_q[b];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q    <= '0;
            cnt_q  <= 5'd0;
            pc_q   <= '0;
            skip_q <= 3'd0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            pc_q   <= pc_d;
            skip_q <= skip_d;
        end
    end

    assign bus.fetch_ready_o = fetch_ready;
    assign bus.insn_valid_o  = insn_valid;
    assign bus.insn_o        = insn;
    assign bus.insn_len_o    = len;
    assign bus.insn_pc_o     = pc_q;
endmodule

// File: tb/tb_ft64v8d_insn_align.sv
// Scoreboard bench for ft64v8d_insn_align: directed fetch words, expected insns queued,
// a negedge monitor pops and compares on every valid/ready handshake.
module tb_ft64v8d_insn_align;
    typedef struct packed {
        logic [55:0] insn;
        logic [2:0]  len;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t me;

    ft64v8d_insn_align_if #(.AMSB(31)) bus ();
    ft64v8d_insn_align #(.AMSB(31)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.insn_valid_o && bus.insn_ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_insn got insn=%h len=%0d pc=%h", bus.insn_o, bus.insn_len_o, bus.insn_pc_o);
            end else begin
                me = sb.pop_front();
                if (bus.insn_o !== me.insn || bus.insn_len_o !== me.len || bus.insn_pc_o !== me.pc) begin
                    errors++;
                    $display("FAIL insn_out got insn=%h len=%0d pc=%h expected insn=%h len=%0d pc=%h",
                             bus.insn_o, bus.insn_len_o, bus.insn_pc_o, me.insn, me.len, me.pc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [55:0] insn, input logic [2:0] len, input logic [31:0] pc);
        exp_t e;
        e.insn = insn; e.len = len; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic fetch(input logic [63:0] w);
        bit done = 1'b0;
        bus.fetch_valid_i = 1'b1;
        bus.fetch_data_i  = w;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.fetch_ready_o) begin
                @(posedge clk);
                done = 1'b1;
            end
        end
        #1;
        bus.fetch_valid_i = 1'b0;
        bus.fetch_data_i  = '0;
        chk("fetch_accept", 64'(done), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.flush_pc_i = '0;
        bus.fetch_valid_i = 1'b0;
        bus.fetch_data_i = '0;
        bus.insn_ready_i = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        bus.flush_i = 1'b1;
        bus.flush_pc_i = pc;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_fetch_ready", 64'(bus.fetch_ready_o), 64'd1);
        chk("rst_insn_valid",  64'(bus.insn_valid_o),  64'd0);
        chk("rst_insn",        64'(bus.insn_o),        64'd0);
        chk("rst_insn_len",    64'(bus.insn_len_o),    64'd1);
        chk("rst_insn_pc",     64'(bus.insn_pc_o),     64'd0);

        // eight single-byte NOPs
        @(posedge clk); #1;
        bus.insn_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) push(56'hEA, 3'd1, 32'(i));
        fetch(64'hEAEAEAEAEAEAEAEA);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("nop_fetch_ready", 64'(bus.fetch_ready_o), 64'd1);
        end
        drain();

        // ADD30 then ADD14 split across two words
        do_reset();
        bus.insn_ready_i = 1'b1;
        push(56'h00151413121105, 3'd6, 32'd0);
        push(56'h00000023222104, 3'd4, 32'd6);
        for (int i = 10; i < 16; i++) push(56'hEA, 3'd1, 32'(i));
        fetch(64'h2104151413121105);
        @(negedge clk);
        chk("add30_valid", 64'(bus.insn_valid_o), 64'd1);
        chk("add30_len",   64'(bus.insn_len_o),   64'd6);
        @(negedge clk);
        chk("add14_wait_valid", 64'(bus.insn_valid_o), 64'd0);
        chk("add14_wait_insn",  64'(bus.insn_o),       64'd0);
        chk("add14_wait_pc",    64'(bus.insn_pc_o),    64'd6);
        chk("add14_wait_len",   64'(bus.insn_len_o),   64'd4);
        @(posedge clk); #1;
        fetch(64'hEAEAEAEAEAEA2322);
        drain();

        // stall decode: fill to 16, third word held until room
        do_reset();
        for (int w = 0; w < 2; w++) begin
            push(56'h3101,   3'd2, 32'(8*w));
            push(56'h333202, 3'd3, 32'(8*w + 2));
            for (int i = 5; i < 8; i++) push(56'hEA, 3'd1, 32'(8*w + i));
        end
        for (int i = 16; i < 24; i++) push(56'hEA, 3'd1, 32'(i));
        fetch(64'hEAEAEA3332023101);
        fetch(64'hEAEAEA3332023101);
        fork
            fetch(64'hEAEAEAEAEAEAEAEA);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("full_fetch_ready", 64'(bus.fetch_ready_o), 64'd0);
                end
                @(posedge clk); #1;
                bus.insn_ready_i = 1'b1;
            end
        join
        drain();

        // flush to 0x105 with 10 bytes queued
        do_reset();
        do_flush(32'd6);
        fetch(64'hEAEA050505050505);
        fetch(64'hEAEAEAEAEAEAEAEA);
        bus.flush_i = 1'b1;
        bus.flush_pc_i = 32'h105;
        bus.fetch_valid_i = 1'b1;
        bus.fetch_data_i = 64'h0101010101010101;
        bus.insn_ready_i = 1'b1;
        @(negedge clk);
        chk("flush_cyc_valid", 64'(bus.insn_valid_o),  64'd0);
        chk("flush_cyc_ready", 64'(bus.fetch_ready_o), 64'd0);
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        bus.fetch_valid_i = 1'b0;
        bus.insn_ready_i = 1'b0;
        @(negedge clk);
        chk("post_flush_valid", 64'(bus.insn_valid_o),  64'd0);
        chk("post_flush_ready", 64'(bus.fetch_ready_o), 64'd1);
        chk("post_flush_pc",    64'(bus.insn_pc_o),     64'h105);
        @(posedge clk); #1;
        push(56'hEA,   3'd1, 32'h105);
        push(56'h4101, 3'd2, 32'h106);
        bus.insn_ready_i = 1'b1;
        fetch(64'h4101EA0505050505);
        drain();

        // dequeue len 3 and accept in the same cycle at cnt 8
        do_reset();
        push(56'h525102, 3'd3, 32'd0);
        for (int i = 3; i < 8; i++) push(56'hEA, 3'd1, 32'(i));
        push(56'h6101,   3'd2, 32'd8);
        push(56'h636202, 3'd3, 32'd10);
        for (int i = 13; i < 16; i++) push(56'hEA, 3'd1, 32'(i));
        fetch(64'hEAEAEAEAEA525102);
        bus.insn_ready_i = 1'b1;
        fetch(64'hEAEAEA6362026101);
        @(negedge clk);
        chk("simul_fetch_ready", 64'(bus.fetch_ready_o), 64'd0);
        chk("simul_pc",          64'(bus.insn_pc_o),     64'd3);
        chk("simul_valid",       64'(bus.insn_valid_o),  64'd1);
        drain();

        // size prefix followed by ADD14
        do_reset();
        bus.insn_ready_i = 1'b1;
`ifdef FT64_PREFIX_FUSE_EN
        push(56'h00007372710442, 3'd5, 32'd0);
`else
        push(56'h42,       3'd1, 32'd0);
        push(56'h73727104, 3'd4, 32'd1);
`endif
        for (int i = 5; i < 8; i++) push(56'hEA, 3'd1, 32'(i));
        fetch(64'hEAEAEA7372710442);
        drain();

        // PC wraps past the top of the address space
        do_reset();
        do_flush(32'hFFFF_FFFE);
        push(56'hEA, 3'd1, 32'hFFFF_FFFE);
        push(56'hEA, 3'd1, 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) push(56'hEA, 3'd1, 32'(i));
        bus.insn_ready_i = 1'b1;
        fetch(64'hEAEA050505050505);
        fetch(64'hEAEAEAEAEAEAEAEA);
        drain();
        @(negedge clk);
        chk("empty_valid", 64'(bus.insn_valid_o), 64'd0);
        chk("empty_insn",  64'(bus.insn_o),       64'd0);
        chk("empty_pc",    64'(bus.insn_pc_o),    64'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ft64v8d_insn_align.md
# ft64v8d_insn_align

Instruction byte-stream aligner for the FT64v8d front end. Accepts 8-byte little-endian fetch words from the instruction cache, buffers them in a 16-byte queue, and hands exactly one variable-length instruction per cycle to decode. It instantiates the ISA length decoder on the queue head byte to size each instruction. It also tracks the instruction PC and handles redirect flushes to arbitrary byte addresses.

## Interface
Parameters:
- AMSB, 31, MSB of byte address (PC width AMSB+1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  redirect; discard all queued bytes
- flush_pc_i  in  AMSB+1  new PC on flush
- fetch_valid_i  in  1  fetch word present
- fetch_data_i  in  64  8 bytes; bits 7:0 = lowest address
- fetch_ready_o  out  1  aligner can accept fetch word this cycle
- insn_valid_o  out  1  complete instruction at queue head
- insn_o  out  56  instruction bytes, head byte in bits 7:0, unused upper bytes zero
- insn_len_o  out  3  instruction length in bytes (1..7)
- insn_pc_o  out  AMSB+1  address of head byte
- insn_ready_i  in  1  decode consumes instruction

## Operation
- Queue: 16 byte registers q[0..15], q[0] = head; count cnt (0..16); head PC register pc; skip register skip (0..7).
- Length: len = decoder(q[0]); unknown opcodes decode to 1.
- fetch_ready_o = (cnt <= 8) & ~flush_i.
- Fetch accept (fetch_valid_i & fetch_ready_o): bytes skip..7 of the word appended at q[cnt'], where cnt' = cnt after same-cycle dequeue; cnt += 8 - skip; skip cleared to 0.
- insn_valid_o = (cnt >= len) & ~flush_i.
- Dequeue (insn_valid_o & insn_ready_i): queue shifts down by len; cnt -= len; pc += len (wraps modulo 2^(AMSB+1)).
- Simultaneous accept and dequeue in one cycle: shift first, then append; cnt = cnt - len + (8 - skip). Must never exceed 16.
- Flush: next state cnt = 0, pc = flush_pc_i, skip = flush_pc_i[2:0]. Any fetch word and any dequeue in the flush cycle are ignored. The first word fetched afterwards is the aligned word containing flush_pc_i.
- Reset: cnt = 0, pc = 0, skip = 0. The q contents are don't-care but the insn_o outputs must be masked to zero when invalid.

## Timing
- Outputs fetch_ready_o, insn_valid_o, insn_o, insn_len_o, insn_pc_o are combinational from registered state. Reset values are 1, 0, 0, 1, 0 respectively.
- Latency: word accepted at edge N; the instruction it completes is valid in cycle N+1.
- Throughput: one instruction per cycle while cnt >= len.
- Empty (cnt = 0): insn_valid_o = 0, insn_len_o reflects stale q[0]. Full (cnt > 8): fetch_ready_o = 0. Back-to-back fetch is sustained when average len >= 8 per word.
- The handshake is valid/ready. Decode may deassert insn_ready_i at any time without loss. Fetch must hold data until accepted.
- Reset takes priority over flush, and flush over everything else. Reset mid-instruction discards partial bytes.

## Configuration
- FT64_PREFIX_FUSE_EN defined: a head byte that is a size prefix (`I_BYTE, `I_UBYTE, `I_HALF, `I_UHALF, `I_WORD, `I_UWORD) is fused with the following instruction.
  - len = 1 + decoder(q[1]).
  - insn_valid_o requires cnt >= 2 and cnt >= fused len.
  - Only one prefix is fused. A second prefix at q[1] has length 1.
- Not defined: prefixes are emitted as standalone 1-byte instructions. Max len = 6.

## Test plan
- Reset, then 8 bytes `I_NOP x8 at PC 0 with insn_ready_i=1 -> 8 consecutive insns, len 1, pc 0..7, fetch_ready_o stays 1.
- Fetch `I_ADD30 (len 6) + `I_ADD14 first 2 bytes, then next word -> ADD30 at pc 0 valid cycle 1; ADD14 at pc 6 valid only after second word, len 4.
- insn_ready_i=0 while fetching 2 words -> cnt=16, fetch_ready_o=0; a third word is held; release consumes all in order.
- flush_i with flush_pc_i=0x105 while queue holds 10 bytes -> next cycle insn_valid_o=0; word from 0x100 accepted with bytes 0..4 dropped; first insn_pc_o=0x105.
- Simultaneous dequeue of len 3 and accept at cnt=8 -> cnt=13, byte order preserved across the shift/append.
- FT64_PREFIX_FUSE_EN: `I_HALF followed by `I_ADD14 -> one insn len 5, pc of prefix; without macro -> len 1 then len 4.
